adder_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one WIDTH-bit unsigned adder among N_REQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time, registers its operands, and computes a (WIDTH+1)-bit sum at exactly that width. It returns the sum tagged with the requester index on a single valid/ready result port. It sits between the requesting datapath units and the shared adder, as the only owner of that adder.

---
 rtl/adder_share_arbiter.sv | 134 +++++++++++++
 tb/tb_adder_share_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that time-shares one WIDTH-bit adder among N_REQ
// requesters and returns each (WIDTH+1)-bit sum tagged with its requester id.
module adder_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH:0]         res_sum,
    output logic [IDW-1:0]         res_id
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam int unsigned   NR_U     = N_REQ;
    localparam int unsigned   WIDTH_U  = WIDTH;
    localparam logic [IDW-1:0] LAST_RST = IDW'(N_REQ - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [IDW-1:0]   r_last;
    logic [IDW-1:0]   r_id;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic             r_res_valid;
    logic [WIDTH:0]   r_res_sum;
    logic [IDW-1:0]   r_res_id;

    logic [IDW-1:0]   w_gnt_id;
    logic             w_gnt_found;
    logic             w_accept;
    int unsigned      w_base;

    // Requester index at offset 'off' past 'base', wrapping at N_REQ.
    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base,
                                                 input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NR_U) begin
            s = s - NR_U;
        end
        return IDW'(s);
    endfunction

    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_id    = '0;
        for (int unsigned k = 1; k <= NR_U; k++) begin
            if (!w_gnt_found && req_valid[rr_index(r_last, k)]) begin
                w_gnt_found = 1'b1;
                w_gnt_id    = rr_index(r_last, k);
            end
        end
    end

    assign w_accept = (r_state == S_IDLE) && w_gnt_found;
    assign w_base   = 32'(w_gnt_id) * WIDTH_U;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_ADD;
            S_ADD:   w_next_state = S_HOLD;
            S_HOLD:  if (res_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Grant is masked during reset so nothing looks accepted while rst is high.
    always_comb begin
        req_ready = '0;
        if (!rst && (r_state == S_IDLE) && w_gnt_found) begin
            req_ready[w_gnt_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last      <= LAST_RST;
            r_id        <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_res_valid <= 1'b0;
            r_res_sum   <= '0;
            r_res_id    <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op_a <= req_a[w_base +: WIDTH];
                        r_op_b <= req_b[w_base +: WIDTH];
                        r_id   <= w_gnt_id;
                        r_last <= w_gnt_id;
                    end
                end
                S_ADD: begin
                    r_res_sum   <= {1'b0, r_op_a} + {1'b0, r_op_b};
                    r_res_id    <= r_id;
                    r_res_valid <= 1'b1;
                end
                S_HOLD: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_valid = r_res_valid;
    assign res_sum   = r_res_sum;
    assign res_id    = r_res_id;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter (N_REQ=4, WIDTH=8) with hand-computed
// expectations; inputs driven on the falling edge, outputs sampled 1 time unit later.
module tb_adder_share_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        res_valid;
    logic        res_ready;
    logic [8:0]  res_sum;
    logic [1:0]  res_id;

    int total = 0;
    int bad   = 0;

    adder_share_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called right after a falling edge with inputs set and res_ready=1:
    // checks grant, the ADD cycle, the HOLD result, and returns in IDLE.
    task automatic serve(input string tag, input logic [3:0] exp_rdy,
                         input int exp_id, input int exp_sum);
        #1;
        check({tag, "_idle_vld"}, 32'(res_valid), 32'd0);
        check({tag, "_rdy"}, 32'(req_ready), 32'(exp_rdy));
        @(negedge clk); #1;
        check({tag, "_add_vld"}, 32'(res_valid), 32'd0);
        check({tag, "_add_rdy"}, 32'(req_ready), 32'd0);
        @(negedge clk); #1;
        check({tag, "_vld"}, 32'(res_valid), 32'd1);
        check({tag, "_sum"}, 32'(res_sum), 32'(exp_sum));
        check({tag, "_id"}, 32'(res_id), 32'(exp_id));
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;

        // Reset state, with requests pending to prove ready is masked
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        check("rst_rdy", 32'(req_ready), 32'd0);
        check("rst_vld", 32'(res_valid), 32'd0);
        check("rst_sum", 32'(res_sum), 32'd0);
        check("rst_id", 32'(res_id), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        @(negedge clk);

        // Single request from requester 2
        req_valid = 4'b0100;
        req_a[16 +: 8] = 8'h12;
        req_b[16 +: 8] = 8'h34;
        serve("single", 4'b0100, 2, 'h46);

        // Rotation after grant to 2: 3 before 1
        req_valid = 4'b1010;
        req_a[8 +: 8]  = 8'h01; req_b[8 +: 8]  = 8'h01;
        req_a[24 +: 8] = 8'h03; req_b[24 +: 8] = 8'h04;
        serve("rot3", 4'b1000, 3, 7);
        serve("rot1", 4'b0010, 1, 2);

        // All four continuously valid after reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_a[i*8 +: 8] = 8'(i);
            req_b[i*8 +: 8] = 8'd10;
        end
        req_valid = 4'b1111;
        serve("all0", 4'b0001, 0, 10);
        serve("all1", 4'b0010, 1, 11);
        serve("all2", 4'b0100, 2, 12);
        serve("all3", 4'b1000, 3, 13);
        serve("all0b", 4'b0001, 0, 10);

        // Carry into bit WIDTH
        req_valid = 4'b0010;
        req_a[8 +: 8] = 8'hFF; req_b[8 +: 8] = 8'hFF;
        serve("carry_ff", 4'b0010, 1, 'h1FE);
        req_a[8 +: 8] = 8'h80; req_b[8 +: 8] = 8'h80;
        serve("carry_80", 4'b0010, 1, 'h100);

        req_valid = '0;
        #1;
        check("idle_none_rdy", 32'(req_ready), 32'd0);
        @(negedge clk);

        // Backpressure: last=1, so 0 wins first
        req_valid = 4'b0011;
        req_a[0 +: 8] = 8'd5; req_b[0 +: 8] = 8'd6;
        req_a[8 +: 8] = 8'd7; req_b[8 +: 8] = 8'd8;
        res_ready = 1'b0;
        #1;
        check("bp_rdy", 32'(req_ready), 32'b0001);
        @(negedge clk); #1;
        check("bp_add_vld", 32'(res_valid), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            check("bp_hold_vld", 32'(res_valid), 32'd1);
            check("bp_hold_sum", 32'(res_sum), 32'd11);
            check("bp_hold_id", 32'(res_id), 32'd0);
            check("bp_hold_rdy", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        res_ready = 1'b1;
        #1;
        check("bp_rel_rdy", 32'(req_ready), 32'd0);
        check("bp_rel_vld", 32'(res_valid), 32'd1);
        @(negedge clk); #1;
        check("bp_next_vld", 32'(res_valid), 32'd0);
        check("bp_next_rdy", 32'(req_ready), 32'b0010);
        @(negedge clk); #1;
        check("bp_next_add", 32'(res_valid), 32'd0);
        @(negedge clk); #1;
        check("bp_next_sum", 32'(res_sum), 32'd15);
        check("bp_next_id", 32'(res_id), 32'd1);
        @(negedge clk);
        req_valid = '0;

        // Reset during ADD
        req_valid = 4'b0100;
        req_a[16 +: 8] = 8'd1; req_b[16 +: 8] = 8'd2;
        #1;
        check("rsta_rdy", 32'(req_ready), 32'b0100);
        @(negedge clk); #1;
        check("rsta_add_vld", 32'(res_valid), 32'd0);
        rst = 1'b1;
        #1;
        check("rsta_in_rdy", 32'(req_ready), 32'd0);
        check("rsta_in_vld", 32'(res_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'b1001;
        req_a[0 +: 8]  = 8'd9; req_b[0 +: 8]  = 8'd9;
        req_a[24 +: 8] = 8'd1; req_b[24 +: 8] = 8'd1;
        serve("rsta_after", 4'b0001, 0, 18);

        // Reset during HOLD
        req_valid = 4'b0100;
        #1;
        check("rsth_rdy", 32'(req_ready), 32'b0100);
        @(negedge clk);
        @(negedge clk); #1;
        check("rsth_hold_vld", 32'(res_valid), 32'd1);
        check("rsth_hold_sum", 32'(res_sum), 32'd3);
        rst = 1'b1;
        #1;
        check("rsth_in_vld", 32'(res_valid), 32'd0);
        check("rsth_in_sum", 32'(res_sum), 32'd0);
        check("rsth_in_rdy", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'b1000;
        serve("rsth_after", 4'b1000, 3, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
